// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one dual-port block memory between the CPU controller (master 0)
//   and a debug/program-loader host (master 1). Writes go out on port A,
//   reads on port B. One access is in flight at a time.
//
//   Arbitration is round-robin on ties. Master 0 may hold ownership with
//   m0_lock across back-to-back accesses. The synchronous read latency of
//   the memory (RD_LAT cycles) is sequenced internally, and read data is
//   returned on a per-master rvalid strobe.
//
// Ports
//   clk, rst                        clock, async active-high reset
//   m0_req/we/addr/wdata/lock       CPU request channel (held until m0_gnt)
//   m0_gnt, m0_rvalid, m0_rdata     CPU grant pulse, read strobe, read data
//   m1_req/we/addr/wdata            loader request channel (no lock)
//   m1_gnt, m1_rvalid, m1_rdata     loader grant pulse, read strobe, read data
//   ena, wea, addra, dina           memory port A (write)
//   enb, addrb, doutb               memory port B (read)
//   busy                            high while an access is in progress
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  // RD_LAT is legal only in 1..3, so two counter bits suffice.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  logic [1:0]        state_r;
  logic [1:0]        cnt_r;
  logic              owner_r;
  logic              last_owner_r;
  logic              we_r;

  logic              m0_gnt_r;
  logic              m1_gnt_r;
  logic              m0_rvalid_r;
  logic              m1_rvalid_r;
  logic              ena_r;
  logic              wea_r;
  logic              enb_r;
  logic [ADDR_W-1:0] addra_r;
  logic [DATA_W-1:0] dina_r;
  logic [ADDR_W-1:0] addrb_r;
  logic              busy_r;
  logic [DATA_W-1:0] m0_hold_r;
  logic [DATA_W-1:0] m1_hold_r;

  logic              any_req_s;
  logic              win_s;
  logic              start_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [1:0]        state_nxt_s;
  logic [1:0]        cnt_nxt_s;
  logic              rd_done_nxt_s;

  // Winner selection: lone requester wins; on a tie the master not granted
  // last wins, except that a locked CPU that owned the last access keeps it.
  always_comb begin
    any_req_s = m0_req | m1_req;
    if (m0_req && !m1_req) begin
      win_s = 1'b0;
    end else if (!m0_req && m1_req) begin
      win_s = 1'b1;
    end else if (!last_owner_r && m0_lock) begin
      win_s = 1'b0;
    end else begin
      win_s = ~last_owner_r;
    end
  end

  // Mux the winner's command fields; a new access starts only from IDLE.
  always_comb begin
    start_s = (state_r == IDLE) && any_req_s;
    if (win_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // Next-state and latency-counter logic. In RD_WAIT the cycle with cnt_r==1
  // is the one where the counter reaches 0, i.e. the rvalid cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = LAT_INIT;
        end
      end
      RD_WAIT: begin
        cnt_nxt_s = cnt_r - 2'd1;
        if (cnt_r == 2'd1) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 2'd0;
      end
    endcase
    rd_done_nxt_s = (state_nxt_s == RD_WAIT) && (cnt_nxt_s == 2'd1);
  end

  // State, command latch and registered memory/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      we_r         <= 1'b0;
      m0_gnt_r     <= 1'b0;
      m1_gnt_r     <= 1'b0;
      m0_rvalid_r  <= 1'b0;
      m1_rvalid_r  <= 1'b0;
      ena_r        <= 1'b0;
      wea_r        <= 1'b0;
      enb_r        <= 1'b0;
      addra_r      <= '0;
      dina_r       <= '0;
      addrb_r      <= '0;
      busy_r       <= 1'b0;
      m0_hold_r    <= '0;
      m1_hold_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      if (start_s) begin
        owner_r      <= win_s;
        last_owner_r <= win_s;
        we_r         <= sel_we_s;
      end
      // Grant and memory enables are timed to land in the ISSUE cycle.
      m0_gnt_r <= start_s && !win_s;
      m1_gnt_r <= start_s && win_s;
      ena_r    <= start_s && sel_we_s;
      wea_r    <= start_s && sel_we_s;
      enb_r    <= start_s && !sel_we_s;
      if (start_s && sel_we_s) begin
        addra_r <= sel_addr_s;
        dina_r  <= sel_wdata_s;
      end
      if (start_s && !sel_we_s) begin
        addrb_r <= sel_addr_s;
      end
      m0_rvalid_r <= rd_done_nxt_s && !owner_r;
      m1_rvalid_r <= rd_done_nxt_s && owner_r;
      if (m0_rvalid_r) begin
        m0_hold_r <= doutb;
      end
      if (m1_rvalid_r) begin
        m1_hold_r <= doutb;
      end
    end
  end

  // doutb is only valid during the rvalid cycle itself, so it is passed
  // straight through then; the hold register keeps it afterwards.
  assign m0_rdata  = m0_rvalid_r ? doutb : m0_hold_r;
  assign m1_rdata  = m1_rvalid_r ? doutb : m1_hold_r;
  assign m0_gnt    = m0_gnt_r;
  assign m1_gnt    = m1_gnt_r;
  assign m0_rvalid = m0_rvalid_r;
  assign m1_rvalid = m1_rvalid_r;
  assign ena       = ena_r;
  assign wea       = wea_r;
  assign addra     = addra_r;
  assign dina      = dina_r;
  assign enb       = enb_r;
  assign addrb     = addrb_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Two instances: g_inst[0] with RD_LAT=1 and
// g_inst[1] with RD_LAT=3, each with its own block-memory model and a
// transaction-level reference model compared every cycle.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0]         rst;
  logic [1:0]         m0_req, m0_we, m0_lock, m1_req, m1_we;
  logic [1:0][AW-1:0] m0_addr, m1_addr;
  logic [1:0][DW-1:0] m0_wdata, m1_wdata;
  logic [1:0]         m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [1:0]         ena, wea, enb, busy;
  logic [1:0][AW-1:0] addra, addrb;
  logic [1:0][DW-1:0] dina, doutb, m0_rdata, m1_rdata;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %h, expected %h", nm, inst, cyc, act, exp);
    end
  endtask

  // Arbitration rule: returns the winning master id.
  function automatic bit pick(input bit r0, input bit r1, input bit lk, input bit lst);
    if (r0 && !r1) return 1'b0;
    if (r1 && !r0) return 1'b1;
    if (!lst && lk) return 1'b0;
    return !lst;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 1) ? 3 : 1;
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [3];
    logic [DW-1:0] mmem [256];
    int            issue_cyc = -100;
    int            end_cyc   = -100;
    int            rv_cyc    = -100;
    int            free_at   = 0;
    bit            own  = 1'b0;
    bit            wr   = 1'b0;
    bit            last = 1'b1;
    logic [AW-1:0] ad   = '0;
    logic [DW-1:0] wd   = '0;
    logic [DW-1:0] rdat = '0;
    logic [DW-1:0] hold0 = '0;
    logic [DW-1:0] hold1 = '0;
    bit            win_m;
    bit            sel_we;
    logic [AW-1:0] sel_ad;
    logic [DW-1:0] sel_wd;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) dut (
      .clk(clk), .rst(rst[g]),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_lock(m0_lock[g]), .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]),
      .ena(ena[g]), .wea(wea[g]), .addra(addra[g]), .dina(dina[g]),
      .enb(enb[g]), .addrb(addrb[g]), .doutb(doutb[g]), .busy(busy[g])
    );

    // Block memory with L-cycle registered read path.
    always @(posedge clk) begin
      if (ena[g] && wea[g]) mem[addra[g]] <= dina[g];
      if (enb[g]) pipe[0] <= mem[addrb[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign doutb[g] = pipe[L-1];

    assign win_m  = pick(m0_req[g], m1_req[g], m0_lock[g], last);
    assign sel_we = win_m ? m1_we[g] : m0_we[g];
    assign sel_ad = win_m ? m1_addr[g] : m0_addr[g];
    assign sel_wd = win_m ? m1_wdata[g] : m0_wdata[g];

    // Reference model: one access record with the cycle numbers of its events.
    always @(posedge clk or posedge rst[g]) begin
      if (rst[g]) begin
        issue_cyc <= -100;
        end_cyc   <= -100;
        rv_cyc    <= -100;
        free_at   <= cyc + 1;
        last      <= 1'b1;
        hold0     <= '0;
        hold1     <= '0;
      end else begin
        if (cyc == rv_cyc) begin
          if (own) hold1 <= rdat;
          else     hold0 <= rdat;
        end
        if (cyc >= free_at && (m0_req[g] || m1_req[g])) begin
          issue_cyc <= cyc + 1;
          own       <= win_m;
          last      <= win_m;
          wr        <= sel_we;
          ad        <= sel_ad;
          wd        <= sel_wd;
          if (sel_we) begin
            mmem[sel_ad] <= sel_wd;
            end_cyc      <= cyc + 1;
            rv_cyc       <= -100;
            free_at      <= cyc + 2;
          end else begin
            rdat    <= mmem[sel_ad];
            rv_cyc  <= cyc + 1 + L;
            end_cyc <= cyc + 1 + L;
            free_at <= cyc + 2 + L;
          end
        end
      end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
      if (cyc >= 3) begin
        chk("gnt0",   g, 32'(m0_gnt[g]),    32'(cyc == issue_cyc && !own));
        chk("gnt1",   g, 32'(m1_gnt[g]),    32'(cyc == issue_cyc && own));
        chk("ena",    g, 32'(ena[g]),       32'(cyc == issue_cyc && wr));
        chk("wea",    g, 32'(wea[g]),       32'(cyc == issue_cyc && wr));
        chk("enb",    g, 32'(enb[g]),       32'(cyc == issue_cyc && !wr));
        chk("busy",   g, 32'(busy[g]),      32'(cyc >= issue_cyc && cyc <= end_cyc));
        chk("rvalid0", g, 32'(m0_rvalid[g]), 32'(cyc == rv_cyc && !own));
        chk("rvalid1", g, 32'(m1_rvalid[g]), 32'(cyc == rv_cyc && own));
        chk("rdata0", g, m0_rdata[g], (cyc == rv_cyc && !own) ? rdat : hold0);
        chk("rdata1", g, m1_rdata[g], (cyc == rv_cyc && own) ? rdat : hold1);
        if (cyc == issue_cyc && wr) begin
          chk("addra", g, 32'(addra[g]), 32'(ad));
          chk("dina",  g, dina[g], wd);
        end
        if (cyc == issue_cyc && !wr) begin
          chk("addrb", g, 32'(addrb[g]), 32'(ad));
        end
      end
    end
  end

  // Grant order log for instance 0.
  int glog[$];
  always @(negedge clk) begin
    if (m0_gnt[0]) glog.push_back(0);
    if (m1_gnt[0]) glog.push_back(1);
  end

  function automatic int g_at(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  task automatic wait_gnt(input int i, input int m, input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (((m == 0) ? m0_gnt[i] : m1_gnt[i]) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    n_chk++;
    if (at < 0) begin
      n_fail++;
      $display("FAIL gnt_timeout inst%0d m%0d: no grant in %0d cycles, grant required", i, m, lim);
    end
  endtask

  task automatic wait_grants(input int n, input int lim);
    int k;
    k = 0;
    while (glog.size() < n && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_chk++;
    if (glog.size() < n) begin
      n_fail++;
      $display("FAIL grant_count: got %0d grants, required %0d", glog.size(), n);
    end
  endtask

  task automatic set_req(input int i, input int m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_req[i] = 1'b1; m0_we[i] = we; m0_addr[i] = a; m0_wdata[i] = d;
    end else begin
      m1_req[i] = 1'b1; m1_we[i] = we; m1_addr[i] = a; m1_wdata[i] = d;
    end
  endtask

  initial begin
    int t0, g, rv_at, mg, rvc;
    rst = 2'b11;
    m0_req = '0; m0_we = '0; m0_lock = '0; m1_req = '0; m1_we = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   0, 32'(busy[0]),   32'd0);
    chk("rst_gnt0",   0, 32'(m0_gnt[0]), 32'd0);
    chk("rst_enb",    0, 32'(enb[0]),    32'd0);
    chk("rst_rdata0", 0, m0_rdata[0],    32'd0);
    rst = 2'b00;
    @(negedge clk);

    // 1: single CPU write
    set_req(0, 0, 1'b1, 8'h10, 32'hDEADBEEF);
    t0 = cyc;
    wait_gnt(0, 0, 10, g);
    chk("t1_gnt_lat", 0, 32'(g - t0), 32'd1);
    chk("t1_ena",   0, 32'(ena[0]), 32'd1);
    chk("t1_wea",   0, 32'(wea[0]), 32'd1);
    chk("t1_addra", 0, 32'(addra[0]), 32'h10);
    chk("t1_dina",  0, dina[0], 32'hDEADBEEF);
    m0_req[0] = 1'b0;
    @(negedge clk);
    chk("t1_busy_low", 0, 32'(busy[0]), 32'd0);

    // 2: CPU read back with RD_LAT=1
    set_req(0, 0, 1'b0, 8'h10, 32'h0);
    t0 = cyc;
    wait_gnt(0, 0, 10, g);
    chk("t2_gnt_lat", 0, 32'(g - t0), 32'd1);
    chk("t2_enb",   0, 32'(enb[0]), 32'd1);
    chk("t2_addrb", 0, 32'(addrb[0]), 32'h10);
    m0_req[0] = 1'b0;
    @(negedge clk);
    chk("t2_rvalid0", 0, 32'(m0_rvalid[0]), 32'd1);
    chk("t2_rdata0",  0, m0_rdata[0], 32'hDEADBEEF);
    chk("t2_rvalid1", 0, 32'(m1_rvalid[0]), 32'd0);
    @(negedge clk);

    // loader writes a second word for the alternation test
    set_req(0, 1, 1'b1, 8'h20, 32'hCAFEF00D);
    wait_gnt(0, 1, 10, g);
    m1_req[0] = 1'b0;
    @(negedge clk);

    // 3: both requesting reads, round-robin
    glog.delete();
    set_req(0, 0, 1'b0, 8'h10, 32'h0);
    set_req(0, 1, 1'b0, 8'h20, 32'h0);
    wait_grants(4, 40);
    m0_req[0] = 1'b0; m1_req[0] = 1'b0;
    chk("t3_g0", 0, 32'(g_at(0)), 32'd0);
    chk("t3_g1", 0, 32'(g_at(1)), 32'd1);
    chk("t3_g2", 0, 32'(g_at(2)), 32'd0);
    chk("t3_g3", 0, 32'(g_at(3)), 32'd1);
    repeat (4) @(negedge clk);

    // 4: CPU lock holds ownership, release hands over to loader
    glog.delete();
    m0_lock[0] = 1'b1;
    set_req(0, 0, 1'b0, 8'h20, 32'h0);
    set_req(0, 1, 1'b0, 8'h10, 32'h0);
    wait_grants(4, 40);
    m0_lock[0] = 1'b0;
    wait_grants(5, 20);
    m0_req[0] = 1'b0; m1_req[0] = 1'b0;
    for (int k = 0; k < 4; k++) chk("t4_lock_g", 0, 32'(g_at(k)), 32'd0);
    chk("t4_unlock_g", 0, 32'(g_at(4)), 32'd1);
    repeat (4) @(negedge clk);

    // 5: reset during an RD_LAT=3 loader read
    set_req(1, 1, 1'b0, 8'h00, 32'h0);
    wait_gnt(1, 1, 10, g);
    m1_req[1] = 1'b0;
    @(posedge clk);
    #1 rst[1] = 1'b1;
    #1;
    chk("t5_busy",   1, 32'(busy[1]),   32'd0);
    chk("t5_enb",    1, 32'(enb[1]),    32'd0);
    chk("t5_gnt1",   1, 32'(m1_gnt[1]), 32'd0);
    chk("t5_rv1",    1, 32'(m1_rvalid[1]), 32'd0);
    chk("t5_rdata1", 1, m1_rdata[1],    32'd0);
    @(posedge clk);
    #1 rst[1] = 1'b0;
    rvc = 0;
    repeat (8) begin
      @(negedge clk);
      if (m1_rvalid[1]) rvc++;
    end
    chk("t5_no_rvalid", 1, 32'(rvc), 32'd0);
    set_req(1, 0, 1'b1, 8'h40, 32'hA5A55A5A);
    t0 = cyc;
    wait_gnt(1, 0, 10, g);
    chk("t5_wr_lat",  1, 32'(g - t0), 32'd1);
    chk("t5_wr_ena",  1, 32'(ena[1]), 32'd1);
    chk("t5_wr_addr", 1, 32'(addra[1]), 32'h40);
    m0_req[1] = 1'b0;
    @(negedge clk);

    // 6: inputs changed during RD_WAIT do not disturb the in-flight read
    set_req(1, 0, 1'b0, 8'h40, 32'h0);
    wait_gnt(1, 0, 10, g);
    m0_req[1] = 1'b0;
    @(negedge clk);
    m0_addr[1] = 8'h41;
    set_req(1, 1, 1'b0, 8'h40, 32'h0);
    rv_at = -1;
    mg = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m0_rvalid[1]) begin
        rv_at = cyc;
        chk("t6_rdata0", 1, m0_rdata[1], 32'hA5A55A5A);
      end
      if (m1_gnt[1]) begin
        mg = cyc;
        break;
      end
    end
    m1_req[1] = 1'b0;
    chk("t6_rv_lat",   1, 32'(rv_at - g), 32'd3);
    chk("t6_m1_gnt",   1, 32'(mg - rv_at), 32'd2);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
